bcd_serial_add_ctrl: RTL

//   Sequencer for a multi-digit BCD addition built on one shared single-digit BCD adder.
//   It latches two DIGITS-digit packed-BCD operands and checks every digit for validity (>9 is invalid).
//   It then steps the single-digit adder LSD->MSD, one digit per clock, with a registered carry.

---
 rtl/bcd_serial_add_ctrl_if.sv | 25 ++
 rtl/bcd_serial_add_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl_if.sv
// Handshake/data bundle between the operand front end and the serial BCD adder sequencer.
// The master drives the request and operands; the slave returns status and the registered result.
interface bcd_serial_add_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  i_start;
    logic [4*DIGITS-1:0]   i_a_bcd;
    logic [4*DIGITS-1:0]   i_b_bcd;
    logic                  i_cin;
    logic                  o_busy;
    logic                  o_done;
    logic [4*DIGITS-1:0]   o_sum;
    logic                  o_cout;
    logic                  o_err;

    modport master (
        output i_start, i_a_bcd, i_b_bcd, i_cin,
        input  o_busy, o_done, o_sum, o_cout, o_err
    );

    modport slave (
        input  i_start, i_a_bcd, i_b_bcd, i_cin,
        output o_busy, o_done, o_sum, o_cout, o_err
    );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit BCD adder sequencer: validates both latched operands, then runs one shared
// single-digit BCD adder LSD->MSD, one digit per clock, with a registered decimal carry.
//
//   state | meaning
//   IDLE  | waiting for start; result registers hold the last outcome
//   CHECK | one cycle scanning every latched digit for values above 9
//   ADD   | one digit per cycle, index 0..DIGITS-1
//   DONE  | one-cycle result-valid pulse, then back to IDLE
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    bcd_serial_add_ctrl_if.slave          bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_ADD   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [4*DIGITS-1:0] r_a;
    logic [4*DIGITS-1:0] r_b;
    logic [4*DIGITS-1:0] r_sum;
    logic [IDX_W-1:0]    r_idx;
    logic                r_carry;
    logic                r_cout;
    logic                r_err;

    logic                w_bad;
    logic [3:0]          w_a_dig;
    logic [3:0]          w_b_dig;
    logic [4:0]          w_t;
    logic [4:0]          w_t_adj;
    logic                w_carry_nxt;
    logic [3:0]          w_digit;

    always_comb begin
        w_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if ((r_a[4*d +: 4] > 4'd9) || (r_b[4*d +: 4] > 4'd9))
                w_bad = 1'b1;
        end
    end

    // Single shared digit adder; values above 9 wrap by adding 6 and keeping the low nibble.
    assign w_a_dig     = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_dig     = r_b[{r_idx, 2'b00} +: 4];
    assign w_t         = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'b0000, r_carry};
    assign w_t_adj     = w_t + 5'd6;
    assign w_carry_nxt = (w_t > 5'd9);
    assign w_digit     = w_carry_nxt ? w_t_adj[3:0] : w_t[3:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_a     <= bus.i_a_bcd;
                        r_b     <= bus.i_b_bcd;
                        r_carry <= bus.i_cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_bad) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_digit;
                    r_carry                    <= w_carry_nxt;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_carry_nxt;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_busy = (r_state == ST_CHECK) || (r_state == ST_ADD);
    assign bus.o_done = (r_state == ST_DONE);
    assign bus.o_sum  = r_sum;
    assign bus.o_cout = r_cout;
    assign bus.o_err  = r_err;
endmodule
